// File: rtl/atf_multi_seed_filter.sv
// Advanced trace filter: N seeds x M bit ranges, drop-matching or keep-only-matching, 2-stage valid/ready pipe.
// Optional macro ATF_HIT_COUNTERS_EN adds per-seed saturating hit counters and a drop counter.
module atf_multi_seed_filter #(
  parameter int DATA_WIDTH      = 512,
  parameter int NUM_SEEDS       = 2,
  parameter int RANGES_PER_SEED = 3,
  parameter int POS_WIDTH       = 10,
  parameter int SEED_SEL_WIDTH  = 1,
  parameter int RANGE_SEL_WIDTH = 2,
  parameter int WORD_IDX_WIDTH  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       cfg_enable,
  input  logic                       cfg_keep_mode,
  input  logic                       cfg_seed_we,
  input  logic [SEED_SEL_WIDTH-1:0]  cfg_seed_sel,
  input  logic [WORD_IDX_WIDTH-1:0]  cfg_seed_word_idx,
  input  logic [31:0]                cfg_seed_word,
  input  logic                       cfg_range_we,
  input  logic [SEED_SEL_WIDTH-1:0]  cfg_range_seed_sel,
  input  logic [RANGE_SEL_WIDTH-1:0] cfg_range_sel,
  input  logic [POS_WIDTH-1:0]       cfg_range_lo,
  input  logic [POS_WIDTH-1:0]       cfg_range_hi,
  input  logic                       cfg_range_en,
  input  logic                       s_valid,
  output logic                       s_ready,
  input  logic [DATA_WIDTH-1:0]      s_data,
  output logic                       m_valid,
  input  logic                       m_ready,
  output logic [DATA_WIDTH-1:0]      m_data,
  output logic                       m_match
`ifdef ATF_HIT_COUNTERS_EN
  ,
  output logic [NUM_SEEDS*32-1:0]    hit_count,
  output logic [31:0]                drop_count
`endif
);

  localparam int NUM_WORDS = DATA_WIDTH / 32;

  logic [NUM_WORDS-1:0][31:0]   seed_q     [NUM_SEEDS];
  logic [DATA_WIDTH-1:0]        mask_q     [NUM_SEEDS][RANGES_PER_SEED];
  logic [RANGES_PER_SEED-1:0]   range_en_q [NUM_SEEDS];
  logic [DATA_WIDTH-1:0]        or_mask    [NUM_SEEDS];

  logic [DATA_WIDTH-1:0]        new_mask;
  logic [POS_WIDTH-1:0]         hi_clamped;
  logic                         seed_wr_ok;
  logic                         range_wr_ok;
  logic [NUM_SEEDS-1:0]         match_vec;

  logic                         s1_vld;
  logic [DATA_WIDTH-1:0]        s1_data;
  logic [NUM_SEEDS-1:0]         s1_match;
  logic                         s1_hit;
  logic                         s1_drop;
  logic                         advance;

  assign seed_wr_ok  = cfg_seed_we && (int'(cfg_seed_sel) < NUM_SEEDS) &&
                       (int'(cfg_seed_word_idx) < NUM_WORDS);
  assign range_wr_ok = cfg_range_we && (int'(cfg_range_seed_sel) < NUM_SEEDS) &&
                       (int'(cfg_range_sel) < RANGES_PER_SEED);

  // Decode the written range into a bit mask; stored on the write edge.
  always_comb begin
    hi_clamped = cfg_range_hi;
    if (int'(cfg_range_hi) >= DATA_WIDTH) begin
      hi_clamped = POS_WIDTH'(DATA_WIDTH - 1);
    end
    new_mask = '0;
    for (int i = 0; i < DATA_WIDTH; i++) begin
      if (cfg_range_en && (cfg_range_lo <= cfg_range_hi) &&
          (cfg_range_lo <= POS_WIDTH'(i)) && (POS_WIDTH'(i) <= hi_clamped)) begin
        new_mask[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < NUM_SEEDS; s++) begin
        seed_q[s]     <= '0;
        range_en_q[s] <= '0;
        for (int r = 0; r < RANGES_PER_SEED; r++) begin
          mask_q[s][r] <= '0;
        end
      end
    end else begin
      if (seed_wr_ok) begin
        seed_q[cfg_seed_sel][cfg_seed_word_idx] <= cfg_seed_word;
      end
      if (range_wr_ok) begin
        mask_q[cfg_range_seed_sel][cfg_range_sel]     <= new_mask;
        range_en_q[cfg_range_seed_sel][cfg_range_sel] <= cfg_range_en;
      end
    end
  end

  always_comb begin
    for (int s = 0; s < NUM_SEEDS; s++) begin
      or_mask[s] = '0;
      for (int r = 0; r < RANGES_PER_SEED; r++) begin
        or_mask[s] = or_mask[s] | mask_q[s][r];
      end
    end
  end

  // An enabled range with an empty mask still arms the seed (matches everything).
  always_comb begin
    match_vec = '0;
    for (int s = 0; s < NUM_SEEDS; s++) begin
      match_vec[s] = (|range_en_q[s]) && (((s_data ^ seed_q[s]) & or_mask[s]) == '0);
    end
  end

  assign advance = !m_valid || m_ready;
  assign s_ready = !s1_vld || advance;
  assign s1_hit  = |s1_match;
  assign s1_drop = cfg_enable && (cfg_keep_mode ? !s1_hit : s1_hit);

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld   <= 1'b0;
      s1_data  <= '0;
      s1_match <= '0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_match  <= 1'b0;
    end else begin
      if (s_ready) begin
        s1_vld <= s_valid;
        if (s_valid) begin
          s1_data  <= s_data;
          s1_match <= match_vec;
        end
      end
      if (advance) begin
        m_valid <= s1_vld && !s1_drop;
        if (s1_vld && !s1_drop) begin
          m_data  <= s1_data;
          m_match <= cfg_enable && s1_hit;
        end
      end
    end
  end

`ifdef ATF_HIT_COUNTERS_EN
  logic stage2_load;
  assign stage2_load = advance && s1_vld;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_count  <= '0;
      drop_count <= '0;
    end else if (stage2_load) begin
      for (int s = 0; s < NUM_SEEDS; s++) begin
        if (cfg_enable && s1_match[s] && (hit_count[s*32 +: 32] != 32'hFFFF_FFFF)) begin
          hit_count[s*32 +: 32] <= hit_count[s*32 +: 32] + 32'd1;
        end
      end
      if (s1_drop && (drop_count != 32'hFFFF_FFFF)) begin
        drop_count <= drop_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_atf_multi_seed_filter.sv
// Scoreboard bench for atf_multi_seed_filter: directed items, expected outputs queued, monitor pops on handshake.
module tb_atf_multi_seed_filter;
  localparam int DW  = 512;
  localparam int NS  = 2;
  localparam int NR  = 3;
  localparam int PW  = 10;
  localparam int SSW = 1;
  localparam int RSW = 2;
  localparam int WIW = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic           cfg_enable, cfg_keep_mode;
  logic           cfg_seed_we;
  logic [SSW-1:0] cfg_seed_sel;
  logic [WIW-1:0] cfg_seed_word_idx;
  logic [31:0]    cfg_seed_word;
  logic           cfg_range_we;
  logic [SSW-1:0] cfg_range_seed_sel;
  logic [RSW-1:0] cfg_range_sel;
  logic [PW-1:0]  cfg_range_lo, cfg_range_hi;
  logic           cfg_range_en;
  logic           s_valid, s_ready;
  logic [DW-1:0]  s_data;
  logic           m_valid, m_ready;
  logic [DW-1:0]  m_data;
  logic           m_match;
`ifdef ATF_HIT_COUNTERS_EN
  logic [NS*32-1:0] hit_count;
  logic [31:0]      drop_count;
`endif

  atf_multi_seed_filter #(
    .DATA_WIDTH(DW), .NUM_SEEDS(NS), .RANGES_PER_SEED(NR), .POS_WIDTH(PW),
    .SEED_SEL_WIDTH(SSW), .RANGE_SEL_WIDTH(RSW), .WORD_IDX_WIDTH(WIW)
  ) dut (
    .clk(clk), .rst(rst),
    .cfg_enable(cfg_enable), .cfg_keep_mode(cfg_keep_mode),
    .cfg_seed_we(cfg_seed_we), .cfg_seed_sel(cfg_seed_sel),
    .cfg_seed_word_idx(cfg_seed_word_idx), .cfg_seed_word(cfg_seed_word),
    .cfg_range_we(cfg_range_we), .cfg_range_seed_sel(cfg_range_seed_sel),
    .cfg_range_sel(cfg_range_sel), .cfg_range_lo(cfg_range_lo),
    .cfg_range_hi(cfg_range_hi), .cfg_range_en(cfg_range_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_match(m_match)
`ifdef ATF_HIT_COUNTERS_EN
    , .hit_count(hit_count), .drop_count(drop_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] data;
    logic          match;
  } exp_t;

  exp_t          exp_q[$];
  exp_t          e;
  int            checks   = 0;
  int            failures = 0;
  int            rdy_mode = 0;   // 0: always ready, 1: toggle, 2: held low
  logic          held_vld = 1'b0;
  logic [DW-1:0] held_data;
  logic          held_match;

  initial begin
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = !m_ready;
        default: m_ready = 1'b0;
      endcase
    end
  end

  // Monitor: stall stability plus in-order scoreboard comparison on each handshake.
  always @(negedge clk) begin
    if (rst) begin
      held_vld = 1'b0;
    end else begin
      if (held_vld) begin
        checks++;
        if (!(m_valid && m_data == held_data && m_match == held_match)) begin
          failures++;
          $display("FAIL stall_hold: got vld=%0b match=%0b data=%h required vld=1 match=%0b data=%h",
                   m_valid, m_match, m_data, held_match, held_data);
        end
      end
      held_vld   = m_valid && !m_ready;
      held_data  = m_data;
      held_match = m_match;
      if (m_valid && m_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_out: got data=%h match=%0b required no output", m_data, m_match);
        end else begin
          e = exp_q.pop_front();
          if (m_data !== e.data || m_match !== e.match) begin
            failures++;
            $display("FAIL out_item: got match=%0b data=%h required match=%0b data=%h",
                     m_match, m_data, e.match, e.data);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] mk(input logic [31:0] w0, input logic [31:0] w3,
                                       input logic [31:0] w15, input logic [31:0] fill);
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[k*32 +: 32] = fill ^ 32'(k);
    d[31:0]    = w0;
    d[127:96]  = w3;
    d[511:480] = w15;
    return d;
  endfunction

  task automatic send(input logic [DW-1:0] d, input logic fwd, input logic mt, output int cyc);
    logic acc;
    acc = 1'b0;
    cyc = 0;
    s_valid = 1'b1;
    s_data  = d;
    if (fwd) exp_q.push_back(exp_t'{data: d, match: mt});
    while (!acc && cyc < 200) begin
      @(negedge clk);
      acc = s_ready;
      @(posedge clk);
      #1;
      cyc++;
    end
    s_valid = 1'b0;
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no s_ready in %0d cycles required accept", cyc);
    end
  endtask

  task automatic wr_seed(input int s, input int w, input logic [31:0] v);
    cfg_seed_we = 1'b1; cfg_seed_sel = SSW'(s); cfg_seed_word_idx = WIW'(w); cfg_seed_word = v;
    tick(1);
    cfg_seed_we = 1'b0;
  endtask

  task automatic wr_range(input int s, input int r, input int lo, input int hi, input logic en);
    cfg_range_we = 1'b1; cfg_range_seed_sel = SSW'(s); cfg_range_sel = RSW'(r);
    cfg_range_lo = PW'(lo); cfg_range_hi = PW'(hi); cfg_range_en = en;
    tick(1);
    cfg_range_we = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick(1);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: got %0d pending required 0", exp_q.size());
    end
  endtask

  initial begin
    int cyc, sum;
    rst = 1'b1; s_valid = 1'b0; s_data = '0;
    cfg_enable = 1'b0; cfg_keep_mode = 1'b0;
    cfg_seed_we = 1'b0; cfg_seed_sel = '0; cfg_seed_word_idx = '0; cfg_seed_word = '0;
    cfg_range_we = 1'b0; cfg_range_seed_sel = '0; cfg_range_sel = '0;
    cfg_range_lo = '0; cfg_range_hi = '0; cfg_range_en = 1'b0;
    tick(3);
    chk("rst_m_valid", 32'(m_valid), 32'd0);
    chk("rst_m_data_nz", 32'(m_data != '0), 32'd0);
    chk("rst_m_match", 32'(m_match), 32'd0);
    chk("rst_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;

    // Drop mode on seed0 low word
    wr_seed(0, 0, 32'hDEAD_BEEF);
    wr_range(0, 0, 0, 31, 1'b1);
    cfg_enable = 1'b1; cfg_keep_mode = 1'b0;
    tick(1);
    send(mk(32'hDEAD_BEEF, 32'h0, 32'h0, 32'h1111_0000), 1'b0, 1'b0, cyc);
    tick(4);
    send(mk(32'hDEAD_BEEE, 32'h0, 32'h0, 32'h2222_0000), 1'b1, 1'b0, cyc);
    chk("latency_c1", 32'(m_valid), 32'd0);
    tick(1);
    chk("latency_c2", 32'(m_valid), 32'd1);
    tick(3);

    // Keep-only mode
    cfg_keep_mode = 1'b1;
    send(mk(32'hDEAD_BEEF, 32'h0, 32'h0, 32'h3333_0000), 1'b1, 1'b1, cyc);
    send(mk(32'hDEAD_BEEE, 32'h0, 32'h0, 32'h4444_0000), 1'b0, 1'b0, cyc);
    send(mk(32'hDEAD_BEEF, 32'h5, 32'h7, 32'h5555_0000), 1'b1, 1'b1, cyc);
    drain();

    // Seed1: bits 103:100 == 4'hA and bits 511:500 == 12'hABC; hi=1023 clamps to 511
    wr_seed(1, 3, 32'h0000_00A0);
    wr_seed(1, 15, 32'hABC0_0000);
    wr_range(1, 0, 100, 103, 1'b1);
    wr_range(1, 1, 500, 1023, 1'b1);
    send(mk(32'h1111_1111, 32'h0000_00A0, 32'hABCF_FFFF, 32'h6666_0000), 1'b1, 1'b1, cyc);
    send(mk(32'h1111_1111, 32'h0000_00A0, 32'hABD0_0000, 32'h6666_0001), 1'b0, 1'b0, cyc);
    send(mk(32'h1111_1111, 32'h0000_00B0, 32'hABC0_0000, 32'h6666_0002), 1'b0, 1'b0, cyc);
    send(mk(32'h1111_1111, 32'h1234_56A9, 32'hABC1_2345, 32'h6666_0003), 1'b1, 1'b1, cyc);
    drain();
    // Empty range (lo>hi) still arms seed0: everything matches
    wr_range(0, 0, 20, 10, 1'b1);
    send(mk(32'h1234_5678, 32'h0, 32'h0, 32'h7777_0000), 1'b1, 1'b1, cyc);
    tick(3);
    cfg_keep_mode = 1'b0;
    send(mk(32'h8765_4321, 32'h0, 32'h0, 32'h7777_0001), 1'b0, 1'b0, cyc);
    drain();
    tick(3);

    // Pass-through, back-to-back with toggling ready, then full-rate
    cfg_enable = 1'b0;
    rdy_mode = 1;
    for (int i = 0; i < 8; i++)
      send(mk(32'(i), 32'(i * 3), 32'(i * 7), 32'h8800_0000 + 32'(i)), 1'b1, 1'b0, cyc);
    drain();
    rdy_mode = 0;
    tick(2);
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      send(mk(32'hC0DE_0000 + 32'(i), 32'h0, 32'h0, 32'h9900_0000 + 32'(i)), 1'b1, 1'b0, cyc);
      sum += cyc;
    end
    chk("full_rate_cycles", 32'(sum), 32'd8);
    drain();

    // Range rewrite in the accept cycle: accepted item uses old config
    cfg_enable = 1'b1; cfg_keep_mode = 1'b0;
    wr_range(0, 0, 0, 31, 1'b1);
    cfg_range_we = 1'b1; cfg_range_seed_sel = '0; cfg_range_sel = '0;
    cfg_range_lo = PW'(0); cfg_range_hi = PW'(31); cfg_range_en = 1'b0;
    send(mk(32'hDEAD_BEEF, 32'h0, 32'h0, 32'hAA00_0000), 1'b0, 1'b0, cyc);
    cfg_range_we = 1'b0;
    chk("rewrite_accept_cycle", 32'(cyc), 32'd1);
    send(mk(32'hDEAD_BEEF, 32'h0, 32'h0, 32'hAA00_0001), 1'b1, 1'b0, cyc);
    drain();

    // Reset with two items in flight
    cfg_enable = 1'b0;
    rdy_mode = 2;
    tick(2);
    send(mk(32'hBB00_0000, 32'h0, 32'h0, 32'h0), 1'b0, 1'b0, cyc);
    send(mk(32'hBB00_0001, 32'h0, 32'h0, 32'h0), 1'b0, 1'b0, cyc);
    tick(1);
    chk("inflight_m_valid", 32'(m_valid), 32'd1);
    chk("inflight_s_ready", 32'(s_ready), 32'd0);
    rst = 1'b1;
    tick(1);
    chk("midrst_m_valid", 32'(m_valid), 32'd0);
    chk("midrst_s_ready", 32'(s_ready), 32'd1);
    rst = 1'b0;
    rdy_mode = 0;
    tick(2);
    wr_range(0, 0, 0, 31, 1'b1);
    cfg_enable = 1'b1; cfg_keep_mode = 1'b0;

`ifdef ATF_HIT_COUNTERS_EN
    chk("cnt_rst_hit0", hit_count[31:0], 32'd0);
    chk("cnt_rst_drop", drop_count, 32'd0);
    for (int i = 0; i < 5; i++)
      send(mk(32'h0, 32'h0, 32'h0, 32'hCC00_0000 + 32'(i)), 1'b0, 1'b0, cyc);
    tick(4);
    chk("cnt_hit0", hit_count[31:0], 32'd5);
    chk("cnt_hit1", hit_count[63:32], 32'd0);
    chk("cnt_drop", drop_count, 32'd5);
`endif

    // Seeds cleared by reset: seed0 is now all-zero
    cfg_keep_mode = 1'b1;
    send(mk(32'h0, 32'h0, 32'h0, 32'hDD00_0000), 1'b1, 1'b1, cyc);
    send(mk(32'hDEAD_BEEF, 32'h0, 32'h0, 32'hDD00_0001), 1'b0, 1'b0, cyc);
    drain();
    tick(4);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
